// File: rtl/circle_orbit_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : circle_orbit_ctrl
// Brief    : Animates a circle symbol around six seven-segment digits along a
//            12-step closed orbit with run/pause/stop, rate and direction.
//            Optional trail display enabled by defining CIRCLE_ORBIT_TRAIL_EN.
// Revision : 1.0 - initial release
// ============================================================================
module circle_orbit_ctrl #(
    parameter int unsigned STEP_DIV = 6_250_000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic       pause_i,
    input  logic       stop_i,
    input  logic       dir_i,
    input  logic [1:0] speed_sel_i,
    output logic [7:0] Hex0_o,
    output logic [7:0] Hex1_o,
    output logic [7:0] Hex2_o,
    output logic [7:0] Hex3_o,
    output logic [7:0] Hex4_o,
    output logic [7:0] Hex5_o,
    output logic [2:0] pos_o,
    output logic       up_o,
    output logic       running_o,
    output logic       lap_o
);

    localparam int unsigned   CW         = $clog2(STEP_DIV + 1);
    localparam logic [CW-1:0] c_step_div = CW'(STEP_DIV);
    localparam logic [CW-1:0] c_cnt_one  = CW'(1);
    localparam logic [7:0]    c_sym_up   = 8'b0110_0011;
    localparam logic [7:0]    c_sym_dn   = 8'b0101_1100;
    localparam logic [3:0]    c_idx_last = 4'd11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    state_t        r_state;
    logic [3:0]    r_idx;
    logic [CW-1:0] r_cnt;
    logic          r_lap;
`ifdef CIRCLE_ORBIT_TRAIL_EN
    logic [3:0]    r_prev_idx;
    logic          r_prev_vld;
`endif

    logic [CW-1:0] w_period;
    logic [CW-1:0] w_period_m1;
    logic          w_step;
    logic [3:0]    w_idx_nxt;
    logic          w_wrap;
    logic          w_active;
    logic [3:0]    w_cur;
    logic [7:0]    w_cur_sym;
    logic [7:0]    w_hex [6];

    // Orbit cell decode: returns {up, pos}
    function automatic logic [3:0] f_cell(input logic [3:0] idx);
        logic [3:0] v;
        case (idx)
            4'd0:    v = {1'b1, 3'd0};
            4'd1:    v = {1'b1, 3'd1};
            4'd2:    v = {1'b1, 3'd2};
            4'd3:    v = {1'b1, 3'd3};
            4'd4:    v = {1'b1, 3'd4};
            4'd5:    v = {1'b1, 3'd5};
            4'd6:    v = {1'b0, 3'd5};
            4'd7:    v = {1'b0, 3'd4};
            4'd8:    v = {1'b0, 3'd3};
            4'd9:    v = {1'b0, 3'd2};
            4'd10:   v = {1'b0, 3'd1};
            4'd11:   v = {1'b0, 3'd0};
            default: v = {1'b1, 3'd0};
        endcase
        return v;
    endfunction

    // The >= compare lets a speed-up take effect on the very next edge
    assign w_period    = c_step_div >> speed_sel_i;
    assign w_period_m1 = w_period - c_cnt_one;
    assign w_step      = (r_cnt >= w_period_m1);

    always_comb begin
        w_idx_nxt = r_idx;
        w_wrap    = 1'b0;
        if (dir_i) begin
            if (r_idx >= c_idx_last) begin
                w_idx_nxt = 4'd0;
                w_wrap    = 1'b1;
            end else begin
                w_idx_nxt = r_idx + 4'd1;
            end
        end else begin
            if (r_idx == 4'd0) begin
                w_idx_nxt = c_idx_last;
                w_wrap    = 1'b1;
            end else begin
                w_idx_nxt = r_idx - 4'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= ST_IDLE;
            r_idx      <= 4'd0;
            r_cnt      <= '0;
            r_lap      <= 1'b0;
`ifdef CIRCLE_ORBIT_TRAIL_EN
            r_prev_idx <= 4'd0;
            r_prev_vld <= 1'b0;
`endif
        end else begin
            r_lap <= 1'b0;
            if (stop_i) begin
                r_state    <= ST_IDLE;
                r_idx      <= 4'd0;
                r_cnt      <= '0;
`ifdef CIRCLE_ORBIT_TRAIL_EN
                r_prev_idx <= 4'd0;
                r_prev_vld <= 1'b0;
`endif
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        // A simultaneous pause outranks start and has no meaning here
                        if (start_i && !pause_i) begin
                            r_state <= ST_RUN;
                            r_idx   <= 4'd0;
                            r_cnt   <= '0;
                        end
                    end
                    ST_RUN: begin
                        if (pause_i) begin
                            r_state <= ST_PAUSE;
                        end else if (w_step) begin
                            r_cnt      <= '0;
                            r_idx      <= w_idx_nxt;
                            r_lap      <= w_wrap;
`ifdef CIRCLE_ORBIT_TRAIL_EN
                            r_prev_idx <= r_idx;
                            r_prev_vld <= 1'b1;
`endif
                        end else begin
                            r_cnt <= r_cnt + c_cnt_one;
                        end
                    end
                    ST_PAUSE: begin
                        if (pause_i) begin
                            r_state <= ST_RUN;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign w_active  = (r_state != ST_IDLE);
    assign w_cur     = f_cell(r_idx);
    assign w_cur_sym = w_cur[3] ? c_sym_up : c_sym_dn;

`ifdef CIRCLE_ORBIT_TRAIL_EN
    logic [3:0] w_prev;
    logic [7:0] w_prev_sym;
    assign w_prev     = f_cell(r_prev_idx);
    assign w_prev_sym = w_prev[3] ? c_sym_up : c_sym_dn;
`endif

    // Current and trail patterns OR together when both land on one digit
    generate
        for (genvar g = 0; g < 6; g++) begin : g_hex
            localparam logic [2:0] c_digit = 3'(g);
            logic [7:0] w_cur_part;
            logic [7:0] w_trail_part;
            assign w_cur_part = (w_active && (w_cur[2:0] == c_digit)) ? w_cur_sym : 8'h00;
`ifdef CIRCLE_ORBIT_TRAIL_EN
            assign w_trail_part = (w_active && r_prev_vld && (w_prev[2:0] == c_digit))
                                  ? w_prev_sym : 8'h00;
`else
            assign w_trail_part = 8'h00;
`endif
            assign w_hex[g] = w_cur_part | w_trail_part;
        end
    endgenerate

    assign Hex0_o    = w_hex[0];
    assign Hex1_o    = w_hex[1];
    assign Hex2_o    = w_hex[2];
    assign Hex3_o    = w_hex[3];
    assign Hex4_o    = w_hex[4];
    assign Hex5_o    = w_hex[5];
    assign pos_o     = w_cur[2:0];
    assign up_o      = w_cur[3];
    assign running_o = (r_state == ST_RUN);
    assign lap_o     = r_lap;

endmodule
`default_nettype wire

// File: tb/tb_circle_orbit_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_circle_orbit_ctrl
// Brief    : Self-checking bench for circle_orbit_ctrl (STEP_DIV = 8) with an
//            orbit-level reference model, directed scenarios and random traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_circle_orbit_ctrl;

    localparam int STEP_DIV = 8;
    localparam logic [7:0] UP = 8'b0110_0011;
    localparam logic [7:0] DN = 8'b0101_1100;
`ifdef CIRCLE_ORBIT_TRAIL_EN
    localparam logic [7:0] TURN_UP = 8'b0111_1111;
    localparam logic [7:0] TURN_DN = 8'b0111_1111;
`else
    localparam logic [7:0] TURN_UP = UP;
    localparam logic [7:0] TURN_DN = DN;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       stop = 1'b0;
    logic       dir = 1'b1;
    logic [1:0] speed = 2'd0;
    logic [7:0] h0, h1, h2, h3, h4, h5;
    logic [2:0] pos;
    logic       up;
    logic       running;
    logic       lap;

    int n_tests = 0;
    int n_fail  = 0;

    circle_orbit_ctrl #(.STEP_DIV(STEP_DIV)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (start),
        .pause_i     (pause),
        .stop_i      (stop),
        .dir_i       (dir),
        .speed_sel_i (speed),
        .Hex0_o      (h0),
        .Hex1_o      (h1),
        .Hex2_o      (h2),
        .Hex3_o      (h3),
        .Hex4_o      (h4),
        .Hex5_o      (h5),
        .pos_o       (pos),
        .up_o        (up),
        .running_o   (running),
        .lap_o       (lap)
    );

    always #5 clk = ~clk;

    // Reference model: mode 0 idle, 1 run, 2 pause; m_prev = -1 means no trail
    int m_mode = 0;
    int m_idx  = 0;
    int m_cnt  = 0;
    int m_prev = -1;
    int m_per  = STEP_DIV;
    bit m_lap  = 1'b0;

    function automatic int cell_pos(input int idx);
        return (idx < 6) ? idx : 11 - idx;
    endfunction

    function automatic logic [7:0] cell_sym(input int idx);
        return (idx < 6) ? UP : DN;
    endfunction

    function automatic logic [7:0] exp_hex(input int d);
        logic [7:0] v;
        v = 8'h00;
        if (m_mode != 0) begin
            if (cell_pos(m_idx) == d) v = v | cell_sym(m_idx);
`ifdef CIRCLE_ORBIT_TRAIL_EN
            if (m_prev >= 0 && cell_pos(m_prev) == d) v = v | cell_sym(m_prev);
`endif
        end
        return v;
    endfunction

    function automatic logic [7:0] get_hex(input int d);
        case (d)
            0: return h0;
            1: return h1;
            2: return h2;
            3: return h3;
            4: return h4;
            default: return h5;
        endcase
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            m_lap = 1'b0;
            if (!rst_n || stop) begin
                m_mode = 0; m_idx = 0; m_cnt = 0; m_prev = -1;
            end else if (pause) begin
                if (m_mode == 1) m_mode = 2;
                else if (m_mode == 2) m_mode = 1;
            end else if (start && m_mode == 0) begin
                m_mode = 1; m_idx = 0; m_cnt = 0;
            end else if (m_mode == 1) begin
                m_per = STEP_DIV >> speed;
                if (m_cnt >= m_per - 1) begin
                    m_cnt  = 0;
                    m_prev = m_idx;
                    m_idx  = (m_idx + (dir ? 1 : 11)) % 12;
                    m_lap  = dir ? (m_idx == 0) : (m_idx == 11);
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                for (int d = 0; d < 6; d++) chk($sformatf("cyc_hex%0d", d), get_hex(d), exp_hex(d));
                chk("cyc_pos", 8'(pos), 8'(cell_pos(m_idx)));
                chk("cyc_up", 8'(up), 8'(m_idx < 6));
                chk("cyc_running", 8'(running), 8'(m_mode == 1));
                chk("cyc_lap", 8'(lap), 8'(m_lap));
            end
        end
    end

    task automatic drive(input logic s, input logic p, input logic t);
        start = s; pause = p; stop = t;
        @(negedge clk);
        #1;
        start = 1'b0; pause = 1'b0; stop = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_hex0"}, h0, 8'h00);
        chk({tag, "_hex3"}, h3, 8'h00);
        chk({tag, "_hex5"}, h5, 8'h00);
        chk({tag, "_pos"}, 8'(pos), 8'd0);
        chk({tag, "_up"}, 8'(up), 8'd1);
        chk({tag, "_running"}, 8'(running), 8'd0);
        chk({tag, "_lap"}, 8'(lap), 8'd0);
    endtask

    // Asserts reset between edges and checks outputs before any clock edge
    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        check_reset_values("async_rst");
        @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        check_reset_values("reset");
        rst_n = 1'b1;

        // Forward orbit
        dir = 1'b1; speed = 2'd0;
        drive(1'b1, 1'b0, 1'b0);
        chk("start_hex0", h0, UP);
        chk("start_running", 8'(running), 8'd1);
        idle(7);
        chk("step7_hex0", h0, UP);
        idle(1);
        chk("step8_hex1", h1, UP);
        chk("model_hex1", exp_hex(1), UP);
        idle(40);
        chk("step48_hex5", h5, TURN_DN);
        chk("step48_up", 8'(up), 8'd0);
        idle(47);
        chk("pre_wrap_lap", 8'(lap), 8'd0);
        idle(1);
        chk("wrap_lap", 8'(lap), 8'd1);
        chk("wrap_hex0", h0, TURN_UP);
        idle(1);
        chk("post_wrap_lap", 8'(lap), 8'd0);
        drive(1'b0, 1'b0, 1'b1);
        chk("stop_running", 8'(running), 8'd0);
        chk("stop_hex0", h0, 8'h00);

        // Reverse orbit: first step wraps 0 -> 11
        dir = 1'b0;
        drive(1'b1, 1'b0, 1'b0);
        idle(8);
        chk("rev_hex0", h0, TURN_DN);
        chk("rev_lap", 8'(lap), 8'd1);
        chk("rev_up", 8'(up), 8'd0);

        // Pause at cnt=3, start ignored while paused, resume
        idle(3);
        drive(1'b0, 1'b1, 1'b0);
        chk("pause_running", 8'(running), 8'd0);
        idle(10);
        drive(1'b1, 1'b0, 1'b0);
        idle(9);
        chk("pause_start_ign", 8'(running), 8'd0);
        chk("pause_hold_pos", 8'(pos), 8'd0);
        drive(1'b0, 1'b1, 1'b0);
        chk("resume_running", 8'(running), 8'd1);
        idle(4);
        chk("resume_no_step", 8'(pos), 8'd0);
        idle(1);
        chk("resume_step_hex1", h1, DN);
        chk("resume_step_pos", 8'(pos), 8'd1);

        // Speed jump 0 -> 3 with cnt=5 steps on the next edge
        idle(5);
        speed = 2'd3;
        drive(1'b0, 1'b0, 1'b0);
        chk("speed_step_hex2", h2, DN);
        idle(1);
        chk("speed_fast_hex3", h3, DN);
        speed = 2'd0;

        // Stop and pause together end in IDLE
        drive(1'b0, 1'b1, 1'b1);
        check_reset_values("stop_pause");

        // Trail behaviour on a plain step and on the 5 -> 6 turnaround
        dir = 1'b1;
        drive(1'b1, 1'b0, 1'b0);
        idle(24);
        chk("idx3_hex3", h3, UP);
`ifdef CIRCLE_ORBIT_TRAIL_EN
        chk("idx3_hex2_trail", h2, UP);
`else
        chk("idx3_hex2_none", h2, 8'h00);
`endif
        idle(24);
        chk("idx6_hex5", h5, TURN_DN);

        // Reset mid-run
        idle(10);
        async_reset();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r >= 96) dir = 1'($urandom);
            if (r >= 97) speed = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 399) == 0) async_reset();
            else drive(r < 5, r >= 5 && r < 8, r == 8);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/circle_orbit_ctrl.md
# circle_orbit_ctrl

Sequencer that animates the circle symbol around the six seven-segment digits. Walks a 12-step closed orbit: upper circle across Hex0→Hex5, then lower circle back Hex5→Hex0. Run/pause/stop control, programmable step rate, selectable direction. Sits between board pushbuttons/switches and the six Hex outputs; replaces manual switch positioning when animation is enabled.

## Interface
- STEP_DIV, default 6_250_000: base clock cycles per orbit step at speed_sel_i=0 (8 steps/s at 50 MHz); legal values ≥ 8.
- clk_i  input  1  system clock; all state on rising edge.
- rst_ni  input  1  reset, asynchronous, active-low.
- start_i  input  1  single-cycle pulse; IDLE→RUN.
- pause_i  input  1  single-cycle pulse; toggles RUN↔PAUSE.
- stop_i  input  1  single-cycle pulse; any state→IDLE.
- dir_i  input  1  1 = forward (idx+1), 0 = reverse (idx−1).
- speed_sel_i  input  2  step period P = STEP_DIV >> speed_sel_i cycles.
- Hex0_o…Hex5_o  output  8 each  segment patterns; up circle 8'b01100011, down circle 8'b01011100, empty 8'b00000000.
- pos_o  output  3  current digit index 0–5.
- up_o  output  1  1 = upper circle, 0 = lower.
- running_o  output  1  high in RUN only.
- lap_o  output  1  one-cycle pulse on orbit wrap.

## Operation
- Registered state: fsm ∈ {IDLE, RUN, PAUSE}, idx (4 bit, 0–11), prescaler cnt (width ≥ clog2(STEP_DIV)), lap_o.
- Orbit mapping: idx 0–5 → pos=idx, up=1; idx 6–11 → pos=11−idx, up=0.
- IDLE: idx=0, cnt=0, all Hex empty, pos_o=0, up_o=1. start_i → RUN.
- RUN: cnt increments each cycle; when cnt ≥ P−1: cnt←0, idx advances per dir_i modulo 12. pause_i → PAUSE. Selected digit shows its symbol, others empty.
- PAUSE: idx and cnt frozen, symbol still displayed. pause_i → RUN, cnt resumes from held value. start_i ignored.
- Priority on simultaneous pulses: stop_i > pause_i > start_i. stop_i in IDLE: no effect.
- Wrap: forward 11→0 and reverse 0→11 both assert lap_o for exactly one cycle.
- dir_i change: no cnt reset; applies at next step.
- speed_sel_i change: new P used immediately; ≥ comparison ensures step on next cycle if cnt already past new P−1.

## Timing
- Reset (async assert, synchronous-safe release): fsm=IDLE, idx=0, cnt=0, lap_o=0; Hex0_o–Hex5_o=8'h00, pos_o=0, up_o=1, running_o=0.
- Hex/pos/up/running_o decoded combinationally from registered fsm/idx (plus trail register); no combinational input→output path.
- start_i sampled at edge k: RUN from edge k, Hex0_o=up circle from edge k; first advance at edge k+P; thereafter one step every P cycles.
- lap_o rises on the same edge idx wraps, falls next edge.
- Reset mid-run: immediate return to reset values, no lap pulse.

## Configuration
- CIRCLE_ORBIT_TRAIL_EN defined: additional register holds previous idx (valid after first step, cleared in IDLE/reset); previous cell's symbol also displayed; if current and previous map to the same digit (turnarounds 5↔6, 11↔0), that digit shows bitwise OR of both patterns (8'b01111111).
- Undefined: only current cell displayed; no trail register.

## Test plan
- Reset: rst_ni low mid-RUN → all Hex 8'h00, running_o=0, pos_o=0, lap_o=0 immediately, without clock edge.
- STEP_DIV=8, speed 0, dir 1, start → Hex0_o=8'b01100011; after 8 cycles Hex1_o up circle; after 48 cycles Hex5_o down circle (idx 6).
- Full forward orbit: 96 cycles after start → idx back to 0, lap_o high exactly 1 cycle; reverse orbit from start → first step to idx 11 (Hex0_o down circle) with lap_o pulse.
- Pause at cnt=3 for 20 cycles, resume → next step after 5 more cycles; start_i during PAUSE ignored.
- speed_sel 0→3 with cnt=5 (P becomes 1) → step on next edge, then every cycle; stop_i and pause_i same cycle → IDLE.
- With CIRCLE_ORBIT_TRAIL_EN: step idx 5→6 → Hex5_o=8'b01111111; step 2→3 → Hex2_o and Hex3_o both up circle.
